// File: rtl/uart_tx_fifo.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte-oriented UART transmitter with an input FIFO. Bytes pushed through the
// valid/ready handshake are queued and serialised on uart_tx_out as frames of
// one start bit, 8 data bits (LSB first), an optional even-parity bit and
// STOP_BITS stop bits. Each bit lasts UART_CPB cycles of clk_slow.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// (XOR of the 8 data bits) between the data bits and the stop bits.
//
// Parameters:
//   UART_CPB    clk_slow cycles per UART bit (>= 2)
//   FIFO_DEPTH  number of byte entries (power of two, >= 2)
//   STOP_BITS   number of stop bits (1 or 2)
//
// Ports:
//   clk_slow     in   UART-domain clock, rising edge
//   resetn       in   synchronous reset, active low
//   tx_data      in   byte to transmit
//   tx_valid     in   tx_data is valid this cycle
//   tx_ready     out  FIFO can accept a byte (registered)
//   uart_tx_out  out  serial line, idles high (registered)
//   busy         out  FIFO non-empty or frame in progress (registered)
//   fifo_count   out  current FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int UART_CPB   = 868,
   parameter int FIFO_DEPTH = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic                        clk_slow,
   input  logic                        resetn,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        uart_tx_out,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;
   localparam int CW   = $clog2(UART_CPB);

   localparam logic [CW-1:0]   BAUD_LOAD = CW'(UART_CPB - 1);
   localparam logic [CW-1:0]   BAUD_ONE  = CW'(1);
   localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(FIFO_DEPTH);
   localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
   localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
   localparam logic [2:0]      LAST_STOP = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state;
   logic [CW-1:0]   baud_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [CNTW-1:0] count_next;
   logic [7:0]      head;
   logic            accept;
   logic            pop;
   logic            bit_end;
   logic            fifo_nonempty;
   logic            line_level;
`ifdef UART_TX_PARITY_EN
   logic            parity_bit;
`endif

   assign head          = mem[rd_ptr];
   assign accept        = tx_valid && tx_ready;
   assign bit_end       = (baud_cnt == '0);
   assign fifo_nonempty = (fifo_count != '0);

   // A frame starts from IDLE as soon as data is queued, or directly from the
   // end of the last stop bit so back-to-back frames have no idle gap.
   assign pop = fifo_nonempty &&
                ((state == IDLE) ||
                 ((state == STOP) && bit_end && (bit_idx == LAST_STOP)));

   // NOTE: every variable assigned in an always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      count_next = fifo_count;
      case ({accept, pop})
         2'b10:   count_next = fifo_count + CNT_ONE;
         2'b01:   count_next = fifo_count - CNT_ONE;
         default: count_next = fifo_count;
      endcase
   end

   // Line level for the current state; registered into uart_tx_out so the
   // serial output never has a combinational path from the inputs.
   always_comb begin
      line_level = 1'b1;
      case (state)
         START:   line_level = 1'b0;
         DATA:    line_level = shreg[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  line_level = parity_bit;
`endif
         default: line_level = 1'b1;
      endcase
   end

   // NOTE: the storage array is deliberately not reset; the pointers and the
   // count alone decide which entries hold valid data.
   always_ff @(posedge clk_slow) begin
      if (accept) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   // NOTE: non-blocking assignments make every register sample pre-edge values,
   // so a pop reads the old head even if the same slot is written this edge.
   always_ff @(posedge clk_slow) begin
      if (!resetn) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
         tx_ready   <= 1'b1;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         fifo_count <= count_next;
         // Ready reflects occupancy after this edge, so a pop only frees a
         // slot for the following cycle.
         tx_ready   <= (count_next != CNT_FULL);
      end
   end

   // Transmit FSM with registered line and busy outputs.
   always_ff @(posedge clk_slow) begin
      if (!resetn) begin
         state       <= IDLE;
         baud_cnt    <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         uart_tx_out <= 1'b1;
         busy        <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit  <= 1'b0;
`endif
      end else begin
         uart_tx_out <= line_level;
         busy        <= fifo_nonempty || (state != IDLE);
         if (pop) begin
            state    <= START;
            shreg    <= head;
            baud_cnt <= BAUD_LOAD;
            bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^head;
`endif
         end else begin
            case (state)
               IDLE: begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
               end
               START: begin
                  if (bit_end) begin
                     state    <= DATA;
                     baud_cnt <= BAUD_LOAD;
                     bit_idx  <= '0;
                  end else begin
                     baud_cnt <= baud_cnt - BAUD_ONE;
                  end
               end
               DATA: begin
                  if (bit_end) begin
                     shreg    <= {1'b0, shreg[7:1]};
                     baud_cnt <= BAUD_LOAD;
                     if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                        bit_idx <= '0;
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                     end
                  end else begin
                     baud_cnt <= baud_cnt - BAUD_ONE;
                  end
               end
`ifdef UART_TX_PARITY_EN
               PARITY: begin
                  if (bit_end) begin
                     state    <= STOP;
                     baud_cnt <= BAUD_LOAD;
                     bit_idx  <= '0;
                  end else begin
                     baud_cnt <= baud_cnt - BAUD_ONE;
                  end
               end
`endif
               STOP: begin
                  // The pop case above already covers a queued next byte.
                  if (bit_end) begin
                     if (bit_idx == LAST_STOP) begin
                        state   <= IDLE;
                        bit_idx <= '0;
                     end else begin
                        bit_idx  <= bit_idx + 3'd1;
                        baud_cnt <= BAUD_LOAD;
                     end
                  end else begin
                     baud_cnt <= baud_cnt - BAUD_ONE;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Self-checking bench for uart_tx_fifo (UART_CPB=4, FIFO_DEPTH=4, STOP_BITS=1).
// A queue-based reference model derives, for every clock edge, the expected
// line level, busy, tx_ready and fifo_count from the frame timing rules:
// a queued byte starts its frame one edge after it is accepted or at the end
// of the previous frame, whichever is later, and the line then carries the
// frame bits one edge later, each for UART_CPB cycles.
// Honours UART_TX_PARITY_EN when defined.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int STOPB = 1;
`ifdef UART_TX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif
   localparam int NBITS = 10 + STOPB - 1 + PBITS;
   localparam int FL    = NBITS * CPB;

   logic       clk_slow = 1'b0;
   logic       resetn;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       uart_tx_out;
   logic       busy;
   logic [2:0] fifo_count;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [7:0] pend [$];
   int         k         = 0;
   int         next_free = 0;
   int         f_pop     = 0;
   logic [7:0] f_byte    = 8'h00;
   bit         f_valid   = 1'b0;
   logic       m_line    = 1'b1;
   logic       m_busy    = 1'b0;
   logic       m_ready   = 1'b1;
   int         m_count   = 0;

   uart_tx_fifo #(
      .UART_CPB   (CPB),
      .FIFO_DEPTH (DEPTH),
      .STOP_BITS  (STOPB)
   ) dut (
      .clk_slow    (clk_slow),
      .resetn      (resetn),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .uart_tx_out (uart_tx_out),
      .busy        (busy),
      .fifo_count  (fifo_count)
   );

   always #5 clk_slow = ~clk_slow;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame bit i: 0 start, 1..8 data LSB first, optional parity, then stop.
   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
      if (i == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Advance the reference model by one rising edge using the driven inputs.
   task automatic model_edge();
      int cnt_before;
      bit active;
      k++;
      if (!resetn) begin
         pend.delete();
         f_valid   = 1'b0;
         next_free = 0;
         m_count   = 0;
         m_ready   = 1'b1;
         m_busy    = 1'b0;
         m_line    = 1'b1;
      end else begin
         cnt_before = pend.size();
         if (pend.size() != 0 && k >= next_free) begin
            f_byte    = pend.pop_front();
            f_pop     = k;
            f_valid   = 1'b1;
            next_free = k + FL;
         end
         if (tx_valid && m_ready) pend.push_back(tx_data);
         m_count = pend.size();
         m_ready = (m_count < DEPTH);
         active  = f_valid && (k >= f_pop + 1) && (k <= f_pop + FL);
         m_busy  = (cnt_before != 0) || active;
         m_line  = active ? frame_bit(f_byte, (k - f_pop - 1) / CPB) : 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk_slow);
      model_edge();
      #1;
      check("line", uart_tx_out, m_line);
      check("busy", busy, m_busy);
      check("ready", tx_ready, m_ready);
      check("count", fifo_count, m_count);
   endtask

   initial begin
      logic [9:0] pat;
`ifdef UART_TX_PARITY_EN
      pat = 10'b0101001010;
`else
      pat = 10'b1101001010;
`endif
      resetn   = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;

      // Reset state
      tick();
      tick();
      check("rst_line", uart_tx_out, 1);
      check("rst_ready", tx_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_count", fifo_count, 0);
      resetn = 1'b1;
      tick();

      // Single byte 0xA5: line low from edge 2, bit pattern, busy drop
      tx_valid = 1'b1;
      tx_data  = 8'hA5;
      tick();
      tx_valid = 1'b0;
      for (int r = 1; r <= FL + 4; r++) begin
         tick();
         if (r == 1) check("a5_pre_start", uart_tx_out, 1);
         if (r >= 2 && ((r - 2) % CPB) == 1 && ((r - 2) / CPB) < 10)
            check("a5_bit", uart_tx_out, pat[(r-2)/CPB]);
         if (r == FL + 1) check("a5_busy_last", busy, 1);
         if (r == FL + 2) check("a5_busy_drop", busy, 0);
      end

      // Back-to-back 0x00, 0xFF: no idle gap between frames
      tx_valid = 1'b1;
      tx_data  = 8'h00;
      tick();
      tx_data  = 8'hFF;
      tick();
      tx_valid = 1'b0;
      for (int r = 2; r <= 2 * FL + 4; r++) begin
         tick();
         if (r == FL + 1)     check("b2b_stop1", uart_tx_out, 1);
         if (r == FL + 2)     check("b2b_start2", uart_tx_out, 0);
         if (r == 2 * FL + 1) check("b2b_busy_last", busy, 1);
         if (r == 2 * FL + 2) check("b2b_busy_drop", busy, 0);
      end

      // Overflow: six random bytes without stalling, sixth dropped
      for (int i = 0; i < 6; i++) begin
         tx_valid = 1'b1;
         tx_data  = 8'($urandom);
         tick();
         if (i == 4) check("ovf_ready_low", tx_ready, 0);
         if (i >= 4) check("ovf_count_full", fifo_count, DEPTH);
      end
      tx_valid = 1'b0;
      repeat (5 * FL + 8) tick();
      check("ovf_drained", busy, 0);

      // Reset during data bit 3 of 0x3C with two bytes queued
      tx_valid = 1'b1;
      tx_data  = 8'h3C;
      tick();
      tx_data  = 8'($urandom);
      tick();
      tx_data  = 8'($urandom);
      tick();
      tx_valid = 1'b0;
      for (int r = 3; r <= 19; r++) tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      check("mid_rst_line", uart_tx_out, 1);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_busy", busy, 0);
      repeat (3 * FL) tick();
      check("mid_rst_quiet", uart_tx_out, 1);

`ifdef UART_TX_PARITY_EN
      // Parity bit: 0x07 -> 1, 0x03 -> 0
      tx_valid = 1'b1;
      tx_data  = 8'h07;
      tick();
      tx_valid = 1'b0;
      for (int r = 1; r <= FL + 4; r++) begin
         tick();
         if (r == 2 + 9 * CPB + 1) check("par_07", uart_tx_out, 1);
      end
      tx_valid = 1'b1;
      tx_data  = 8'h03;
      tick();
      tx_valid = 1'b0;
      for (int r = 1; r <= FL + 4; r++) begin
         tick();
         if (r == 2 + 9 * CPB + 1) check("par_03", uart_tx_out, 0);
      end
`endif

      // Random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         tx_valid = ($urandom_range(0, 3) == 0);
         tx_data  = 8'($urandom);
         resetn   = ($urandom_range(0, 199) != 0);
         tick();
      end
      tx_valid = 1'b0;
      resetn   = 1'b1;
      repeat (6 * FL) tick();
      check("final_idle_line", uart_tx_out, 1);
      check("final_idle_count", fifo_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
